// File: rtl/bitbakery_serial_rx_if.sv
// -----------------------------------------------------------------------------
// bitbakery_serial_rx_if
// Bundles the serial line and every decoded output of the BitBakery receiver.
//   entrada_serial : serial line into the receiver, idle high
//   byte_data      : last received byte
//   byte_valid     : 1-cycle pulse, byte_data updated
//   minigame       : D0[5:4] of last good packet (2'b11 = no game)
//   estado         : D0[3:0] of last good packet
//   jogada         : {D2[5], D1[5:0]} of last good packet
//   dificuldade    : D2[4] of last good packet
//   packet_valid   : 1-cycle pulse, packet fields updated
//   frame_error    : 1-cycle pulse, stop bit sampled low
//   seq_error      : 1-cycle pulse, tag order/payload violation or timeout
// Modports: slave = receiver side, master = line driver / output consumer.
// -----------------------------------------------------------------------------
interface bitbakery_serial_rx_if;
  logic       entrada_serial;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [1:0] minigame;
  logic [3:0] estado;
  logic [6:0] jogada;
  logic       dificuldade;
  logic       packet_valid;
  logic       frame_error;
  logic       seq_error;

  modport slave (
    input  entrada_serial,
    output byte_data, byte_valid, minigame, estado, jogada, dificuldade,
    output packet_valid, frame_error, seq_error
  );

  modport master (
    output entrada_serial,
    input  byte_data, byte_valid, minigame, estado, jogada, dificuldade,
    input  packet_valid, frame_error, seq_error
  );
endinterface

// File: rtl/bitbakery_serial_rx.sv
// -----------------------------------------------------------------------------
// bitbakery_serial_rx
// UART (8N1) receiver for the 4-byte BitBakery status packet. Bytes carry a
// tag in bits [7:6] (00, 01, 10, 11 for D0..D3); a complete, well-ordered
// packet is committed to the minigame/estado/jogada/dificuldade outputs.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   rx    : bitbakery_serial_rx_if.slave (serial line in, decoded outputs)
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit, >= 4
//   TIMEOUT_CLKS : max idle cycles between bytes of one packet
// -----------------------------------------------------------------------------
module bitbakery_serial_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  bitbakery_serial_rx_if.slave  rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;
  typedef enum logic [1:0] {WAIT_D0, WAIT_D1, WAIT_D2, WAIT_D3}      pkt_state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] r_sync;
  logic       w_rx;

  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= 2'b11;  // line idles high, so no false start after reset
    else        r_sync <= {r_sync[0], rx.entrada_serial};
  end

  assign w_rx = r_sync[1];

  // ---------------------------------------------------------------- bit FSM
  bit_state_t       r_bit_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rx_prev;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_frame_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_state   <= BIT_IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rx_prev     <= 1'b1;
      r_byte_data   <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_prev     <= w_rx;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_bit_state)
        BIT_IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_bit_state <= BIT_START;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
          end
        end
        BIT_START: begin
          // Half a bit after the edge: still low means a real start bit.
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt   <= '0;
            r_bit_state <= w_rx ? BIT_IDLE : BIT_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        BIT_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};  // LSB arrives first
            if (r_bit_cnt == 3'd7) r_bit_state <= BIT_STOP;
            else                   r_bit_cnt   <= r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        BIT_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt   <= '0;
            r_bit_state <= BIT_IDLE;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_error <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_bit_state <= BIT_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- packet FSM
  pkt_state_t      r_pkt_state;
  logic [5:0]      r_sh_d0;
  logic [5:0]      r_sh_d1;
  logic [1:0]      r_sh_d2;      // D2[5:4]; D2[3:0] must be zero
  logic [TO_W-1:0] r_to_cnt;
  logic [1:0]      r_minigame;
  logic [3:0]      r_estado;
  logic [6:0]      r_jogada;
  logic            r_dificuldade;
  logic            r_packet_valid;
  logic            r_seq_error;
  logic [1:0]      w_tag;

  assign w_tag = r_byte_data[7:6];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pkt_state    <= WAIT_D0;
      // NOTE: the shadow registers are only read after being written, but
      // they are small and resetting them keeps simulation X-free.
      r_sh_d0        <= '0;
      r_sh_d1        <= '0;
      r_sh_d2        <= '0;
      r_to_cnt       <= '0;
      r_minigame     <= 2'b11;
      r_estado       <= '0;
      r_jogada       <= '0;
      r_dificuldade  <= 1'b0;
      r_packet_valid <= 1'b0;
      r_seq_error    <= 1'b0;
    end else begin
      r_packet_valid <= 1'b0;
      r_seq_error    <= 1'b0;
      if (r_frame_error) begin
        // Broken byte aborts the packet; frame_error alone reports it.
        r_pkt_state <= WAIT_D0;
        r_to_cnt    <= '0;
      end else if (r_byte_valid) begin
        r_to_cnt <= '0;
        if (w_tag == 2'b00) begin
          r_sh_d0     <= r_byte_data[5:0];
          r_pkt_state <= WAIT_D1;
          if (r_pkt_state != WAIT_D0) r_seq_error <= 1'b1;
        end else begin
          case (r_pkt_state)
            WAIT_D1: begin
              if (w_tag == 2'b01) begin
                r_sh_d1     <= r_byte_data[5:0];
                r_pkt_state <= WAIT_D2;
              end else begin
                r_seq_error <= 1'b1;
                r_pkt_state <= WAIT_D0;
              end
            end
            WAIT_D2: begin
              if (w_tag == 2'b10 && r_byte_data[3:0] == 4'd0) begin
                r_sh_d2     <= r_byte_data[5:4];
                r_pkt_state <= WAIT_D3;
              end else begin
                r_seq_error <= 1'b1;
                r_pkt_state <= WAIT_D0;
              end
            end
            WAIT_D3: begin
              r_pkt_state <= WAIT_D0;
              if (r_byte_data == 8'b1100_0000) begin
                r_minigame     <= r_sh_d0[5:4];
                r_estado       <= r_sh_d0[3:0];
                r_jogada       <= {r_sh_d2[1], r_sh_d1};
                r_dificuldade  <= r_sh_d2[0];
                r_packet_valid <= 1'b1;
              end else begin
                r_seq_error <= 1'b1;
              end
            end
            default: r_seq_error <= 1'b1;  // non-00 byte while waiting for D0
          endcase
        end
      end else if (r_pkt_state != WAIT_D0 && r_bit_state == BIT_IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_seq_error <= 1'b1;
          r_pkt_state <= WAIT_D0;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else if (r_pkt_state == WAIT_D0) begin
        r_to_cnt <= '0;
      end
    end
  end

  assign rx.byte_data    = r_byte_data;
  assign rx.byte_valid   = r_byte_valid;
  assign rx.frame_error  = r_frame_error;
  assign rx.minigame     = r_minigame;
  assign rx.estado       = r_estado;
  assign rx.jogada       = r_jogada;
  assign rx.dificuldade  = r_dificuldade;
  assign rx.packet_valid = r_packet_valid;
  assign rx.seq_error    = r_seq_error;

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_bitbakery_serial_rx
// Directed bench for bitbakery_serial_rx with CLKS_PER_BIT=8, TIMEOUT_CLKS=200.
// Stimulus pushes expected events into a queue; an independent monitor pops
// and compares whenever the DUT pulses byte_valid/frame_error/seq_error/
// packet_valid.
// -----------------------------------------------------------------------------
module tb_bitbakery_serial_rx;
  localparam int CPB = 8;
  localparam int TO  = 200;

  typedef enum int {EV_BYTE, EV_FERR, EV_SERR, EV_PKT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic [1:0] mg;
    logic [3:0] est;
    logic [6:0] jog;
    logic       dif;
  } ev_t;

  logic clock;
  logic reset;
  bitbakery_serial_rx_if bus ();

  bitbakery_serial_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (bus.slave)
  );

  ev_t    exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_events = 0;
  longint cycle = 0;
  longint last_byte_cycle = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic handle(input ev_kind_t k);
    ev_t e;
    n_events++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", int'(k));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      if (k == e.kind) begin
        case (k)
          EV_BYTE: begin
            check("byte_data", 32'(bus.byte_data), 32'(e.data));
            last_byte_cycle = cycle;
          end
          EV_PKT: begin
            check("pkt_minigame", 32'(bus.minigame), 32'(e.mg));
            check("pkt_estado", 32'(bus.estado), 32'(e.est));
            check("pkt_jogada", 32'(bus.jogada), 32'(e.jog));
            check("pkt_dificuldade", 32'(bus.dificuldade), 32'(e.dif));
            check("pkt_latency", 32'(cycle - last_byte_cycle), 32'd1);
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(negedge clock) begin
    cycle++;
    if (reset) begin
      if (bus.byte_valid)   handle(EV_BYTE);
      if (bus.frame_error)  handle(EV_FERR);
      if (bus.seq_error)    handle(EV_SERR);
      if (bus.packet_valid) handle(EV_PKT);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic push_byte(input logic [7:0] d);
    ev_t e;
    e = '{kind: EV_BYTE, data: d, mg: '0, est: '0, jog: '0, dif: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input ev_kind_t k);
    ev_t e;
    e = '{kind: k, data: '0, mg: '0, est: '0, jog: '0, dif: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [1:0] mg, input logic [3:0] est,
                          input logic [6:0] jog, input logic dif);
    ev_t e;
    e = '{kind: EV_PKT, data: '0, mg: mg, est: est, jog: jog, dif: dif};
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    bus.entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.entrada_serial = d[i];
      repeat (CPB) @(negedge clock);
    end
    bus.entrada_serial = stop_bit;
    repeat (CPB) @(negedge clock);
    bus.entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  // Sends D0..D3 with expected byte and packet events queued beforehand.
  task automatic send_packet(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [1:0] mg,
                             input logic [3:0] est, input logic [6:0] jog,
                             input logic dif);
    push_byte(d0); push_byte(d1); push_byte(d2); push_byte(8'hC0);
    push_pkt(mg, est, jog, dif);
    send_byte(d0, 1'b1);
    send_byte(d1, 1'b1);
    send_byte(d2, 1'b1);
    send_byte(8'hC0, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (20) @(negedge clock);
  endtask

  task automatic check_fields(input string tag, input logic [1:0] mg,
                              input logic [3:0] est, input logic [6:0] jog,
                              input logic dif);
    check({tag, "_minigame"}, 32'(bus.minigame), 32'(mg));
    check({tag, "_estado"}, 32'(bus.estado), 32'(est));
    check({tag, "_jogada"}, 32'(bus.jogada), 32'(jog));
    check({tag, "_dificuldade"}, 32'(bus.dificuldade), 32'(dif));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int ev_snap;
    reset = 1'b0;
    bus.entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    check_fields("reset", 2'b11, 4'h0, 7'h00, 1'b0);
    check("reset_byte_data", 32'(bus.byte_data), 32'h0);
    check("reset_pulses", 32'({bus.byte_valid, bus.packet_valid, bus.frame_error, bus.seq_error}), 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // 1: nominal packet 26 55 B0 C0
    send_packet(8'h26, 8'h55, 8'hB0, 2'd2, 4'd6, 7'h55, 1'b1);
    wait_drain("t1_drain");
    check_fields("t1_hold", 2'd2, 4'd6, 7'h55, 1'b1);

    // 2: reset in the middle of D1
    push_byte(8'h26);
    send_byte(8'h26, 1'b1);
    bus.entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus.entrada_serial = 1'(8'h55 >> i);
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b0;
    bus.entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    check_fields("t2_in_reset", 2'b11, 4'h0, 7'h00, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    wait_drain("t2_partial_drain");
    check_fields("t2_after_reset", 2'b11, 4'h0, 7'h00, 1'b0);
    send_packet(8'h26, 8'h55, 8'hB0, 2'd2, 4'd6, 7'h55, 1'b1);
    wait_drain("t2_drain");

    // 3: D1 with stop bit low, then a different full packet
    push_byte(8'h26);
    push_ev(EV_FERR);
    send_byte(8'h26, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_drain("t3_ferr_drain");
    check_fields("t3_hold", 2'd2, 4'd6, 7'h55, 1'b1);
    send_packet(8'h1B, 8'h6A, 8'hA0, 2'd1, 4'hB, 7'h6A, 1'b0);
    wait_drain("t3_drain");

    // 4: D1 skipped
    push_byte(8'h26);
    push_byte(8'hA0);
    push_ev(EV_SERR);
    send_byte(8'h26, 1'b1);
    send_byte(8'hA0, 1'b1);
    wait_drain("t4_drain");
    check_fields("t4_hold", 2'd1, 4'hB, 7'h6A, 1'b0);

    // 5: inter-byte timeout, trailing bytes rejected in WAIT_D0
    push_byte(8'h26);
    push_byte(8'h55);
    push_ev(EV_SERR);
    push_byte(8'hB0);
    push_ev(EV_SERR);
    push_byte(8'hC0);
    push_ev(EV_SERR);
    send_byte(8'h26, 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (250) @(negedge clock);
    send_byte(8'hB0, 1'b1);
    send_byte(8'hC0, 1'b1);
    wait_drain("t5_drain");
    check_fields("t5_hold", 2'd1, 4'hB, 7'h6A, 1'b0);

    // 6: 2-cycle glitch on idle line
    ev_snap = n_events;
    bus.entrada_serial = 1'b0;
    repeat (2) @(negedge clock);
    bus.entrada_serial = 1'b1;
    repeat (50) @(negedge clock);
    check("t6_no_events", 32'(n_events - ev_snap), 32'd0);
    send_packet(8'h26, 8'h55, 8'hB0, 2'd2, 4'd6, 7'h55, 1'b1);
    wait_drain("t6_drain");
    check_fields("t6_final", 2'd2, 4'd6, 7'h55, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
